fifo_push_arbiter: RTL and testbench

- Shares the push side of one `std_fifo` instance between N producer requesters.
- Arbitration is round-robin with bounded burst lock.
- Backpressure comes from the FIFO's full/almost-full flags.
- Sequences a FIFO clear between bursts so a clear never lands mid-burst.
- Sits directly in front of `std_fifo`; its outputs drive `i_push`, `i_data` and `i_clear` of that FIFO.

---
 rtl/fifo_push_arbiter_pkg.sv | 41 ++++
 rtl/fifo_push_arbiter_if.sv | 36 +++
 rtl/fifo_push_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_push_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO push arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, CLEAR)
//   rr_sel_t    : result of a round-robin scan (found flag + index)
//   rr_select() : round-robin scan over up to RR_MAX_N requesters
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      CLEAR = 2'd2
   } arb_state_t;

   // Upper bound on requester count supported by rr_select.
   localparam int RR_MAX_N = 32;
   localparam int RR_IDX_W = 5;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_sel_t;

   // Returns the first set bit of valid[n-1:0], scanning ptr, ptr+1, ...
   // modulo n. ptr must be below n, so one conditional subtraction wraps.
   function automatic rr_sel_t rr_select(input logic [RR_MAX_N-1:0] valid,
                                         input int unsigned         ptr,
                                         input int unsigned         n);
      rr_sel_t     sel;
      int unsigned j;
      sel = '0;
      for (int k = 0; k < RR_MAX_N; k++) begin
         j = ptr + unsigned'(k);
         if (j >= n) j = j - n;
         if ((unsigned'(k) < n) && !sel.found && valid[j[RR_IDX_W-1:0]]) begin
            sel.found = 1'b1;
            sel.idx   = j[RR_IDX_W-1:0];
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: bundles the requester side and the FIFO push side
// of the arbiter.
//   i_valid / i_data / o_ready      : N requesters, data slice k at [k*WIDTH +: WIDTH]
//   i_clear_req / o_clear_ack       : clear request pulse and its acknowledge
//   i_fifo_full / i_fifo_almost_full: backpressure from the FIFO
//   o_fifo_push / o_fifo_data / o_fifo_clear : drive the FIFO push port
//   o_grant                         : current grant index (meaningful in GRANT)
// modport master: the requesters + FIFO environment; modport slave: the arbiter.
interface fifo_push_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 8
);

   logic [N-1:0]         i_valid;
   logic [N*WIDTH-1:0]   i_data;
   logic [N-1:0]         o_ready;
   logic                 i_clear_req;
   logic                 o_clear_ack;
   logic                 i_fifo_full;
   logic                 i_fifo_almost_full;
   logic                 o_fifo_push;
   logic [WIDTH-1:0]     o_fifo_data;
   logic                 o_fifo_clear;
   logic [$clog2(N)-1:0] o_grant;

   modport master (
      output i_valid, i_data, i_clear_req, i_fifo_full, i_fifo_almost_full,
      input  o_ready, o_clear_ack, o_fifo_push, o_fifo_data, o_fifo_clear, o_grant
   );

   modport slave (
      input  i_valid, i_data, i_clear_req, i_fifo_full, i_fifo_almost_full,
      output o_ready, o_clear_ack, o_fifo_push, o_fifo_data, o_fifo_clear, o_grant
   );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// fifo_arb_rr_pick: combinational round-robin selector.
//   valid : per-requester request vector
//   ptr   : highest-priority index
//   found : some requester is valid
//   idx   : first valid index at or after ptr (wrapping)
module fifo_arb_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   rr_sel_t sel;

   always_comb begin
      sel   = rr_select(RR_MAX_N'(valid), 32'(ptr), N);
      found = sel.found;
      idx   = sel.idx[IW-1:0];
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares the push port of one FIFO between N requesters.
// Round-robin arbitration with bursts of at most MAX_BURST beats per grant;
// FIFO full stalls a burst, almost-full only blocks new grants. A clear
// request is held pending until the current burst ends, then issued as a
// single-cycle clear + ack.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : fifo_push_arbiter_if.slave (requesters, clear handshake, FIFO port)
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   fifo_push_arbiter_if.slave   bus
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t      state, state_nx;
   logic [IW-1:0]   g, g_nx;
   logic [IW-1:0]   p, p_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            clear_pending, clear_pending_nx;

   logic [WIDTH-1:0] slice [N];
   logic [IW-1:0]    g_inc;
   logic             found_p, found_inc;
   logic [IW-1:0]    idx_p, idx_inc;
   logic             want_clear, arb_ok, cur_valid, push, last_beat, burst_end;

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign slice[k] = bus.i_data[k*WIDTH +: WIDTH];
   end

   assign g_inc = (g == IW'(N - 1)) ? '0 : g + 1'b1;

   // Two selectors: one from the stored pointer (used from IDLE), one from
   // the pointer the burst end is about to install, so a back-to-back
   // regrant needs no idle cycle.
   fifo_arb_rr_pick #(.N(N)) u_pick_p (
      .valid (bus.i_valid),
      .ptr   (p),
      .found (found_p),
      .idx   (idx_p)
   );

   fifo_arb_rr_pick #(.N(N)) u_pick_inc (
      .valid (bus.i_valid),
      .ptr   (g_inc),
      .found (found_inc),
      .idx   (idx_inc)
   );

   assign want_clear = clear_pending | bus.i_clear_req;
   assign arb_ok     = ~bus.i_fifo_almost_full & ~want_clear;
   assign cur_valid  = bus.i_valid[g];
   assign push       = (state == GRANT) & cur_valid & ~bus.i_fifo_full;
   assign last_beat  = (int'(cnt) + 1) == MAX_BURST;
   // A full stall with valid held is neither a beat nor a burst end.
   assign burst_end  = (push & last_beat) | ~cur_valid;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         g             <= '0;
         p             <= '0;
         cnt           <= '0;
         clear_pending <= 1'b0;
      end else begin
         state         <= state_nx;
         g             <= g_nx;
         p             <= p_nx;
         cnt           <= cnt_nx;
         clear_pending <= clear_pending_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx         = state;
      g_nx             = g;
      p_nx             = p;
      cnt_nx           = cnt;
      clear_pending_nx = want_clear;
      case (state)
         IDLE: begin
            if (want_clear) begin
               state_nx = CLEAR;
            end else if (arb_ok && found_p) begin
               state_nx = GRANT;
               g_nx     = idx_p;
               cnt_nx   = '0;
            end
         end
         GRANT: begin
            if (push) cnt_nx = cnt + 1'b1;
            if (burst_end) begin
               p_nx = g_inc;
               if (want_clear) begin
                  state_nx = CLEAR;
               end else if (arb_ok && found_inc) begin
                  g_nx   = idx_inc;
                  cnt_nx = '0;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         CLEAR: begin
            // A request landing in the clear cycle is covered by this clear.
            state_nx         = IDLE;
            clear_pending_nx = 1'b0;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.o_ready      = '0;
      bus.o_fifo_push  = 1'b0;
      bus.o_fifo_data  = '0;
      bus.o_fifo_clear = 1'b0;
      bus.o_clear_ack  = 1'b0;
      bus.o_grant      = '0;
      case (state)
         GRANT: begin
            bus.o_ready[g]  = ~bus.i_fifo_full;
            bus.o_fifo_push = push;
            bus.o_fifo_data = slice[g];
            bus.o_grant     = g;
         end
         CLEAR: begin
            bus.o_fifo_clear = 1'b1;
            bus.o_clear_ack  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized bench for fifo_push_arbiter against a transaction-level model:
// the model tracks only who owns the push port, how many beats the owner
// has delivered, the rotation start point and whether a clear is owed.
module tb_fifo_push_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fifo_push_arbiter_if #(.N(N), .WIDTH(W)) bus ();

   fifo_push_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   // Model: owner = -1 means nobody holds the port.
   int     owner     = -1;
   int     taken     = 0;
   int     start     = 0;
   bit     owed      = 1'b0;
   bit     clear_now = 1'b0;
   logic [N-1:0] acc = '0;

   // Stimulus knobs
   int           p_rise = 50;
   int           p_drop = 0;
   int           p_full = 0;
   int           p_af   = 0;
   int           p_clr  = 0;
   int           p_rst  = 0;
   bit           all_valid = 1'b0;
   bit           force_rst = 1'b0;
   logic [N-1:0] en_mask   = '1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int from);
      for (int k = 0; k < N; k++) begin
         if (v[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         if (!en_mask[k]) begin
            bus.i_valid[k] = 1'b0;
         end else if (bus.i_valid[k] && acc[k]) begin
            bus.i_data[k*W +: W] = W'($urandom_range(0, 255));
            bus.i_valid[k] = all_valid || ($urandom_range(0, 99) < p_rise);
         end else if (bus.i_valid[k]) begin
            if (!all_valid && ($urandom_range(0, 99) < p_drop)) bus.i_valid[k] = 1'b0;
         end else if (all_valid || ($urandom_range(0, 99) < p_rise)) begin
            bus.i_data[k*W +: W] = W'($urandom_range(0, 255));
            bus.i_valid[k] = 1'b1;
         end
      end
      bus.i_fifo_full        = ($urandom_range(0, 99) < p_full);
      bus.i_fifo_almost_full = ($urandom_range(0, 99) < p_af);
      bus.i_clear_req        = !bus.i_clear_req && ($urandom_range(0, 99) < p_clr);
      rst_n = !(force_rst || ($urandom_range(0, 99) < p_rst));
   endtask

   task automatic check_and_step();
      logic [N-1:0]  v;
      logic [N-1:0]  exp_ready;
      logic          exp_push;
      logic [W-1:0]  exp_data;
      logic [1:0]    exp_grant;
      bit            want_clear, allowed, done;
      v          = bus.i_valid;
      exp_ready  = '0;
      exp_push   = 1'b0;
      exp_data   = '0;
      exp_grant  = '0;
      if (owner >= 0) begin
         exp_ready[owner] = !bus.i_fifo_full;
         exp_push         = v[owner] && !bus.i_fifo_full;
         exp_data         = bus.i_data[owner*W +: W];
         exp_grant        = 2'(owner);
      end
      chk("ready", bus.o_ready, exp_ready);
      chk("push",  bus.o_fifo_push, exp_push);
      chk("data",  bus.o_fifo_data, exp_data);
      chk("grant", bus.o_grant, exp_grant);
      chk("clear", bus.o_fifo_clear, clear_now);
      chk("ack",   bus.o_clear_ack, clear_now);

      acc = '0;
      if (exp_push) acc[owner] = 1'b1;

      want_clear = owed || bus.i_clear_req;
      allowed    = !bus.i_fifo_almost_full && !want_clear;
      if (!rst_n) begin
         owner = -1; taken = 0; start = 0; owed = 0; clear_now = 0;
      end else if (clear_now) begin
         clear_now = 0;
         owed      = 0;
      end else if (owner < 0) begin
         owed = want_clear;
         if (want_clear) begin
            clear_now = 1;
         end else if (allowed) begin
            owner = pick(v, start);
            taken = 0;
         end
      end else begin
         owed = want_clear;
         if (exp_push) taken++;
         done = (exp_push && taken == MB) || !v[owner];
         if (done) begin
            start = (owner + 1) % N;
            owner = -1;
            if (want_clear) begin
               clear_now = 1;
            end else if (allowed) begin
               owner = pick(v, start);
               taken = 0;
            end
         end
      end
   endtask

   task automatic run_cycle();
      @(posedge clk);
      #1;
      drive_inputs();
      #3;
      check_and_step();
      cyc++;
   endtask

   task automatic set_knobs(input int rise, input int drop, input int full,
                            input int af, input int clr, input int rst,
                            input bit allv, input logic [N-1:0] mask);
      p_rise = rise; p_drop = drop; p_full = full;
      p_af = af; p_clr = clr; p_rst = rst;
      all_valid = allv; en_mask = mask;
   endtask

   initial begin
      bus.i_valid            = '0;
      bus.i_data             = '0;
      bus.i_clear_req        = 1'b0;
      bus.i_fifo_full        = 1'b0;
      bus.i_fifo_almost_full = 1'b0;
      rst_n                  = 1'b0;
      repeat (2) @(posedge clk);

      // Reset held with random traffic: every output must stay 0.
      set_knobs(80, 0, 20, 0, 0, 0, 1'b0, '1);
      force_rst = 1'b1;
      repeat (3) run_cycle();
      force_rst = 1'b0;

      // All requesters continuously valid: rotating 4-beat bursts.
      set_knobs(100, 0, 0, 0, 0, 0, 1'b1, '1);
      repeat (40) run_cycle();

      // Only requester 2, with drops: regrant to itself and forfeits.
      set_knobs(70, 15, 0, 0, 0, 0, 1'b0, 4'b0100);
      repeat (100) run_cycle();

      // Full stalls in the middle of bursts.
      set_knobs(80, 5, 35, 0, 0, 0, 1'b0, '1);
      repeat (300) run_cycle();

      // Clear requests and almost-full blocking.
      set_knobs(70, 5, 10, 25, 12, 0, 1'b0, '1);
      repeat (300) run_cycle();

      // Everything mixed, including resets mid-burst.
      set_knobs(60, 10, 20, 15, 6, 2, 1'b0, '1);
      repeat (1500) run_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
